// File: rtl/q_pulse_decoder.sv
// Charge-pulse decoder: qualifies synchronized pulses, counts them per fixed window and
// reports the saturated charge code over valid/ready. Define Q_DEC_GLITCH_CNT_EN for glitch_cnt.
module q_pulse_decoder #(
   parameter int BUS_WIDTH      = 10,
   parameter int PULSE_DURATION = 3,
   parameter int Q_PER_PULSE    = 60,
   parameter int WINDOW_CYCLES  = 128
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 q_serialized,
   output logic [BUS_WIDTH-1:0] i_meas,
   output logic                 i_valid,
   input  logic                 i_ready,
   output logic                 overrun,
`ifdef Q_DEC_GLITCH_CNT_EN
   output logic [7:0]           glitch_cnt,
`endif
   output logic                 busy
);
   localparam int RUN_W  = $clog2(PULSE_DURATION + 1);
   localparam int WIN_W  = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
   localparam int CNT_W  = $clog2(WINDOW_CYCLES + 1);
   localparam int PROD_W = CNT_W + BUS_WIDTH + 32;
   localparam logic [PROD_W-1:0] CODE_MAX = PROD_W'({BUS_WIDTH{1'b1}});
   localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

   state_t               state_q, state_d;
   logic                 sync1_q, sync2_q, hist_q;
   logic [RUN_W-1:0]     run_q, run_d;
   logic [WIN_W-1:0]     win_cnt_q, win_cnt_d;
   logic [CNT_W-1:0]     pulse_cnt_q, pulse_cnt_d;
   logic [BUS_WIDTH-1:0] i_meas_q, i_meas_d;
   logic                 i_valid_q, i_valid_d;
   logic                 overrun_q, overrun_d;
   logic                 fall, qual_fall, close_win, accept;
   logic [CNT_W-1:0]     closing_cnt;
   logic [PROD_W-1:0]    prod;

   // run_q holds the high-run length seen up to the previous cycle, so on the fall
   // cycle it is exactly the width of the pulse that just ended (saturated).
   always_comb begin
      fall      = hist_q & ~sync2_q;
      qual_fall = fall && (run_q >= RUN_W'(PULSE_DURATION));
      run_d     = run_q;
      if (!sync2_q)
         run_d = '0;
      else if (run_q != RUN_W'(PULSE_DURATION))
         run_d = run_q + RUN_W'(1);
   end

   always_comb begin
      state_d     = state_q;
      win_cnt_d   = win_cnt_q;
      pulse_cnt_d = pulse_cnt_q;
      i_meas_d    = i_meas_q;
      i_valid_d   = i_valid_q;
      overrun_d   = overrun_q;
      close_win   = 1'b0;
      accept      = i_valid_q & i_ready;
      closing_cnt = pulse_cnt_q + CNT_W'(qual_fall);
      case (state_q)
         IDLE: begin
            if (start)
               state_d = ARM;
         end
         ARM: begin
            if (!start) begin
               state_d = IDLE;
            end else if (!sync2_q) begin
               state_d     = MEASURE;
               win_cnt_d   = '0;
               pulse_cnt_d = '0;
            end
         end
         MEASURE: begin
            if (!start) begin
               state_d = IDLE;
            end else if (win_cnt_q == WIN_LAST) begin
               close_win   = 1'b1;
               win_cnt_d   = '0;
               pulse_cnt_d = '0;
            end else begin
               win_cnt_d   = win_cnt_q + WIN_W'(1);
               pulse_cnt_d = closing_cnt;
            end
         end
         default: state_d = IDLE;
      endcase

      // A fall on the closing cycle belongs to the closing window.
      prod = PROD_W'(closing_cnt) * PROD_W'(Q_PER_PULSE);
      if (close_win) begin
         i_meas_d  = (prod > CODE_MAX) ? CODE_MAX[BUS_WIDTH-1:0] : prod[BUS_WIDTH-1:0];
         i_valid_d = 1'b1;
         if (i_valid_q && !i_ready)
            overrun_d = 1'b1;
      end else if (accept) begin
         i_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         hist_q      <= 1'b0;
         run_q       <= '0;
         state_q     <= IDLE;
         win_cnt_q   <= '0;
         pulse_cnt_q <= '0;
         i_meas_q    <= '0;
         i_valid_q   <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         sync1_q     <= q_serialized;
         sync2_q     <= sync1_q;
         hist_q      <= sync2_q;
         run_q       <= run_d;
         state_q     <= state_d;
         win_cnt_q   <= win_cnt_d;
         pulse_cnt_q <= pulse_cnt_d;
         i_meas_q    <= i_meas_d;
         i_valid_q   <= i_valid_d;
         overrun_q   <= overrun_d;
      end
   end

`ifdef Q_DEC_GLITCH_CNT_EN
   logic       glitch_fall;
   logic [7:0] glitch_cnt_q, glitch_cnt_d;

   always_comb begin
      glitch_fall  = fall && !qual_fall;
      glitch_cnt_d = glitch_cnt_q;
      if ((state_q == MEASURE) && glitch_fall && (glitch_cnt_q != 8'hFF))
         glitch_cnt_d = glitch_cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         glitch_cnt_q <= 8'd0;
      else
         glitch_cnt_q <= glitch_cnt_d;
   end

   assign glitch_cnt = glitch_cnt_q;
`endif

   assign i_meas  = i_meas_q;
   assign i_valid = i_valid_q;
   assign overrun = overrun_q;
   assign busy    = (state_q != IDLE);
endmodule

// File: tb/tb_q_pulse_decoder.sv
// Self-checking bench for q_pulse_decoder: directed scenarios plus random pulse trains
// checked against a window/pulse-list reference model.
module tb_q_pulse_decoder;
   localparam int BW   = 10;
   localparam int PD   = 3;
   localparam int QPP  = 60;
   localparam int WIN  = 128;
   localparam int MAXC = 8192;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          q_serialized = 1'b0;
   logic          i_ready = 1'b0;
   logic [BW-1:0] i_meas;
   logic          i_valid, overrun, busy;
`ifdef Q_DEC_GLITCH_CNT_EN
   logic [7:0]    glitch_cnt;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;
   int cyc = 0;
   bit q_at [0:MAXC-1];
   int obs_cyc[$], obs_val[$], exp_cyc[$], exp_val[$];

   q_pulse_decoder #(.BUS_WIDTH(BW), .PULSE_DURATION(PD), .Q_PER_PULSE(QPP), .WINDOW_CYCLES(WIN)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .q_serialized(q_serialized),
      .i_meas(i_meas), .i_valid(i_valid), .i_ready(i_ready), .overrun(overrun),
`ifdef Q_DEC_GLITCH_CNT_EN
      .glitch_cnt(glitch_cnt),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Every accepted result, tagged with the index of the clock edge it followed.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && i_valid === 1'b1 && i_ready === 1'b1) begin
         obs_cyc.push_back(cyc);
         obs_val.push_back(int'(i_meas));
      end
   end

   // Drive inputs just after a rising edge; they are sampled at edge cyc+1.
   task automatic drive(input bit q, input bit st, input bit rdy);
      @(posedge clk);
      #1;
      q_serialized = q;
      start        = st;
      i_ready      = rdy;
      if (cyc + 1 < MAXC) q_at[cyc + 1] = q;
   endtask

   task automatic pulses(input int n, input int w, input int gap, input bit rdy);
      for (int p = 0; p < n; p++) begin
         repeat (w) drive(1'b1, 1'b1, rdy);
         repeat (gap) drive(1'b0, 1'b1, rdy);
      end
   endtask

   task automatic clear_hist();
      for (int i = 0; i < MAXC; i++) q_at[i] = 1'b0;
      obs_cyc.delete();
      obs_val.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) drive(1'b0, 1'b0, 1'b1);
      rst_n = 1'b1;
      clear_hist();
      drive(1'b0, 1'b0, 1'b1);
   endtask

   // Reference model: the line seen by the decoder at cycle c is q sampled at edge c-2.
   // Measuring starts the cycle after the first armed cycle with a low line; each pulse
   // belongs to the window containing its fall cycle, and window k reports at m+128k+127.
   task automatic build_expect(input int s, input int t);
      int m, nwin, a, w, f, k, v;
      int cnt[$];
      exp_cyc.delete();
      exp_val.delete();
      m = -1;
      for (int c = s + 1; c < t; c++)
         if (m < 0 && c >= 2 && !q_at[c - 2]) m = c + 1;
      if (m < 0) return;
      nwin = 0;
      while (m + WIN * nwin + WIN - 1 < t) nwin++;
      for (int i = 0; i < nwin; i++) cnt.push_back(0);
      a = 0;
      while (a < t + 8 && a < MAXC) begin
         if (q_at[a]) begin
            w = 0;
            while (a + w < MAXC && q_at[a + w]) w++;
            f = a + w + 2;
            if (w >= PD && f >= m) begin
               k = (f - m) / WIN;
               if (k < nwin) cnt[k] = cnt[k] + 1;
            end
            a = a + w;
         end else begin
            a++;
         end
      end
      for (int i = 0; i < nwin; i++) begin
         v = cnt[i] * QPP;
         exp_cyc.push_back(m + WIN * i + WIN - 1);
         exp_val.push_back((v > (1 << BW) - 1) ? (1 << BW) - 1 : v);
      end
   endtask

   task automatic test_reset();
      int s, got;
      rst_n = 1'b0;
      for (int i = 0; i < 12; i++) drive((i % 4) < 2 && i < 10, 1'b1, 1'b1);
      @(negedge clk);
      total_cnt++; if (i_meas !== '0) $display("FAIL reset_i_meas: got %0d want 0", i_meas); else pass_cnt++;
      total_cnt++; if (i_valid !== 1'b0) $display("FAIL reset_i_valid: got %b want 0", i_valid); else pass_cnt++;
      total_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
      clear_hist();
      rst_n = 1'b1;
      s = cyc + 1;
      @(negedge clk);
      total_cnt++; if (busy !== 1'b1) $display("FAIL reset_release_arm_busy: got %b want 1", busy); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (busy !== 1'b1) $display("FAIL reset_release_measure_busy: got %b want 1", busy); else pass_cnt++;
      repeat (135) drive(1'b0, 1'b1, 1'b1);
      build_expect(s, cyc);
      got = (obs_cyc.size() > 0) ? obs_cyc[0] : -1;
      total_cnt++; if (exp_cyc.size() < 1 || got != exp_cyc[0]) $display("FAIL reset_first_window_time: got %0d want %0d", got, (exp_cyc.size() > 0) ? exp_cyc[0] : -1); else pass_cnt++;
      got = (obs_val.size() > 0) ? obs_val[0] : -1;
      total_cnt++; if (got != 0) $display("FAIL reset_first_window_value: got %0d want 0", got); else pass_cnt++;
   endtask

   task automatic test_nominal();
      int s, got;
      do_reset();
      drive(1'b0, 1'b1, 1'b1);
      s = cyc + 1;
      pulses(8, 3, 13, 1'b1);
      repeat (8) drive(1'b0, 1'b1, 1'b1);
      build_expect(s, cyc);
      @(negedge clk);
      total_cnt++; if (obs_val.size() != 1) $display("FAIL nominal_count: got %0d results want 1", obs_val.size()); else pass_cnt++;
      got = (obs_val.size() > 0) ? obs_val[0] : -1;
      total_cnt++; if (got != 480) $display("FAIL nominal_i_meas: got %0d want 480", got); else pass_cnt++;
      got = (obs_cyc.size() > 0) ? obs_cyc[0] : -1;
      total_cnt++; if (exp_cyc.size() < 1 || got != exp_cyc[0]) $display("FAIL nominal_latency: got %0d want %0d", got, (exp_cyc.size() > 0) ? exp_cyc[0] : -1); else pass_cnt++;
      total_cnt++; if (overrun !== 1'b0) $display("FAIL nominal_overrun: got %b want 0", overrun); else pass_cnt++;
      total_cnt++; if (i_valid !== 1'b0) $display("FAIL nominal_valid_dropped: got %b want 0", i_valid); else pass_cnt++;
   endtask

   task automatic test_glitch();
      int got;
      do_reset();
      drive(1'b0, 1'b1, 1'b1);
      for (int p = 0; p < 4; p++) begin
         repeat (3) drive(1'b1, 1'b1, 1'b1);
         repeat (5) drive(1'b0, 1'b1, 1'b1);
         repeat (2) drive(1'b1, 1'b1, 1'b1);
         repeat (6) drive(1'b0, 1'b1, 1'b1);
      end
      pulses(4, 3, 13, 1'b1);
      repeat (8) drive(1'b0, 1'b1, 1'b1);
      @(negedge clk);
      got = (obs_val.size() > 0) ? obs_val[0] : -1;
      total_cnt++; if (got != 480) $display("FAIL glitch_i_meas: got %0d want 480", got); else pass_cnt++;
`ifdef Q_DEC_GLITCH_CNT_EN
      total_cnt++; if (glitch_cnt !== 8'd4) $display("FAIL glitch_cnt: got %0d want 4", glitch_cnt); else pass_cnt++;
`endif
   endtask

   task automatic test_saturation();
      int got;
      do_reset();
      drive(1'b0, 1'b1, 1'b1);
      pulses(20, 3, 3, 1'b1);
      repeat (12) drive(1'b0, 1'b1, 1'b1);
      @(negedge clk);
      got = (obs_val.size() > 0) ? obs_val[0] : -1;
      total_cnt++; if (got != 1023) $display("FAIL saturation_i_meas: got %0d want 1023", got); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      do_reset();
      drive(1'b0, 1'b1, 1'b0);
      pulses(8, 3, 13, 1'b0);
      pulses(16, 3, 5, 1'b0);
      repeat (6) drive(1'b0, 1'b1, 1'b0);
      @(negedge clk);
      total_cnt++; if (i_meas !== 10'd960) $display("FAIL backpressure_i_meas: got %0d want 960", i_meas); else pass_cnt++;
      total_cnt++; if (i_valid !== 1'b1) $display("FAIL backpressure_i_valid: got %b want 1", i_valid); else pass_cnt++;
      total_cnt++; if (overrun !== 1'b1) $display("FAIL backpressure_overrun: got %b want 1", overrun); else pass_cnt++;
      drive(1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 1'b0);
      @(negedge clk);
      total_cnt++; if (i_valid !== 1'b0) $display("FAIL backpressure_accept_clears: got %b want 0", i_valid); else pass_cnt++;
      total_cnt++; if (overrun !== 1'b1) $display("FAIL backpressure_overrun_sticky: got %b want 1", overrun); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int s;
      do_reset();
      drive(1'b0, 1'b1, 1'b0);
      s = cyc + 1;
      pulses(2, 3, 13, 1'b0);
      while (cyc + 2 < s + 133) drive(1'b0, 1'b1, 1'b0);
      pulses(4, 3, 13, 1'b0);
      while (cyc + 2 < s + 257) drive(1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 1'b0);
      @(negedge clk);
      total_cnt++; if (i_valid !== 1'b1) $display("FAIL accept_on_close_valid: got %b want 1", i_valid); else pass_cnt++;
      total_cnt++; if (i_meas !== 10'd240) $display("FAIL accept_on_close_i_meas: got %0d want 240", i_meas); else pass_cnt++;
      total_cnt++; if (overrun !== 1'b0) $display("FAIL accept_on_close_overrun: got %b want 0", overrun); else pass_cnt++;
   endtask

   task automatic test_arm_line_high();
      int s, got;
      do_reset();
      repeat (3) drive(1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b1);
      s = cyc + 1;
      repeat (2) drive(1'b1, 1'b1, 1'b1);
      repeat (4) drive(1'b0, 1'b1, 1'b1);
      pulses(2, 3, 13, 1'b1);
      repeat (110) drive(1'b0, 1'b1, 1'b1);
      build_expect(s, cyc);
      @(negedge clk);
      got = (obs_val.size() > 0) ? obs_val[0] : -1;
      total_cnt++; if (got != 120) $display("FAIL arm_high_partial_excluded: got %0d want 120", got); else pass_cnt++;
      got = (obs_cyc.size() > 0) ? obs_cyc[0] : -1;
      total_cnt++; if (exp_cyc.size() < 1 || got != exp_cyc[0]) $display("FAIL arm_high_window_time: got %0d want %0d", got, (exp_cyc.size() > 0) ? exp_cyc[0] : -1); else pass_cnt++;
   endtask

   task automatic test_stop();
      do_reset();
      drive(1'b0, 1'b1, 1'b0);
      pulses(2, 3, 13, 1'b0);
      repeat (100) drive(1'b0, 1'b1, 1'b0);
      pulses(3, 3, 13, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      repeat (150) drive(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      total_cnt++; if (busy !== 1'b0) $display("FAIL stop_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (i_valid !== 1'b1) $display("FAIL stop_pending_valid: got %b want 1", i_valid); else pass_cnt++;
      total_cnt++; if (i_meas !== 10'd120) $display("FAIL stop_pending_i_meas: got %0d want 120", i_meas); else pass_cnt++;
      total_cnt++; if (overrun !== 1'b0) $display("FAIL stop_overrun: got %b want 0", overrun); else pass_cnt++;
   endtask

   task automatic test_random();
      int s, w, g, n;
      bit pre;
      for (int r = 0; r < 3; r++) begin
         do_reset();
         pre = 1'($urandom_range(0, 1));
         repeat (3) drive(pre, 1'b0, 1'b1);
         drive(pre, 1'b1, 1'b1);
         s = cyc + 1;
         while (cyc < s + 560) begin
            w = $urandom_range(1, 5);
            g = $urandom_range(1, 12);
            repeat (w) drive(1'b1, 1'b1, 1'b1);
            repeat (g) drive(1'b0, 1'b1, 1'b1);
         end
         repeat (10) drive(1'b0, 1'b1, 1'b1);
         build_expect(s, cyc);
         total_cnt++;
         if (obs_val.size() != exp_val.size()) $display("FAIL random%0d_count: got %0d results want %0d", r, obs_val.size(), exp_val.size()); else pass_cnt++;
         n = (obs_val.size() < exp_val.size()) ? obs_val.size() : exp_val.size();
         for (int i = 0; i < n; i++) begin
            total_cnt++;
            if (obs_val[i] != exp_val[i]) $display("FAIL random%0d_win%0d_i_meas: got %0d want %0d", r, i, obs_val[i], exp_val[i]); else pass_cnt++;
            total_cnt++;
            if (obs_cyc[i] != exp_cyc[i]) $display("FAIL random%0d_win%0d_time: got %0d want %0d", r, i, obs_cyc[i], exp_cyc[i]); else pass_cnt++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_glitch();
      test_saturation();
      test_backpressure();
      test_back_to_back();
      test_arm_line_high();
      test_stop();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
